// File: rtl/gauss_frame_if.sv
// Pixel-stream bundle shared by the Gaussian stage output and the frame controller output.
interface gauss_frame_if #(
  parameter int DATA_W = 8
);
  logic              vsync;
  logic              href;
  logic              clken;
  logic [DATA_W-1:0] gray;

  modport master (output vsync, href, clken, gray);
  modport slave  (input  vsync, href, clken, gray);
endinterface

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer after the 3x3 Gaussian stage: tracks pixel position, applies the
// border policy to pixels whose window ran off the image, and measures each frame.
module gauss_frame_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int BORDER     = 1,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_border_mode,
  input  logic [7:0]       cfg_fill,
  gauss_frame_if.slave     in_frame,
  gauss_frame_if.master    out_frame,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cols,
  output logic [CNT_W-1:0] frame_rows,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {WAIT_SOF, IN_FRAME, EOF} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] W_C     = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] H_C     = CNT_W'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] B_LO    = CNT_W'(BORDER);
  localparam logic [CNT_W-1:0] C_HI    = CNT_W'(IMG_WIDTH - BORDER);
  localparam logic [CNT_W-1:0] R_HI    = CNT_W'(IMG_HEIGHT - BORDER);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] border_pix(input logic [1:0] mode,
                                            input logic [7:0] pix,
                                            input logic [7:0] fill);
    case (mode)
      2'd1:    return 8'd0;
      2'd2:    return fill;
      default: return pix;
    endcase
  endfunction

  state_t           state;
  logic             vsync_p1, href_p1;
  logic [CNT_W-1:0] col, row, cols_capt;
  logic             err;
  logic [1:0]       mode_sh;
  logic [7:0]       fill_sh;

  logic             vs_rise, vs_fall, href_fall, sof, gate, line_end, eof_now, is_border;
  logic [CNT_W-1:0] col_cur, row_cur, row_nxt, capt_nxt;
  logic             err_nxt;
  logic [1:0]       mode_cur;
  logic [7:0]       fill_cur, pix_cur;

  // Stage p0: edge detect, position of the current pixel, border policy
  always_comb begin
    vs_rise   = in_frame.vsync & ~vsync_p1;
    vs_fall   = ~in_frame.vsync & vsync_p1;
    href_fall = ~in_frame.href & href_p1;
    sof       = vs_rise && (state != IN_FRAME);
    gate      = (state == IN_FRAME) || sof;
    line_end  = href_fall && (state == IN_FRAME);
    eof_now   = vs_fall && (state == IN_FRAME);
    // The start-of-frame pixel sees cleared counters and the live config it is about to latch.
    col_cur   = sof ? '0 : col;
    row_cur   = sof ? '0 : row;
    mode_cur  = sof ? cfg_border_mode : mode_sh;
    fill_cur  = sof ? cfg_fill : fill_sh;
    is_border = (col_cur < B_LO) || (col_cur >= C_HI) ||
                (row_cur < B_LO) || (row_cur >= R_HI);
    pix_cur   = is_border ? border_pix(mode_cur, in_frame.gray, fill_cur) : in_frame.gray;
    row_nxt   = line_end ? sat_inc(row) : row;
    err_nxt   = err | (line_end && (col != W_C));
    capt_nxt  = (line_end && (row == '0)) ? col : cols_capt;
  end

  // Stage p1: registered outputs, FSM, counters and published frame measurements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= WAIT_SOF;
      vsync_p1        <= 1'b1;   // a frame already in progress at reset release is not seen as a rise
      href_p1         <= 1'b0;
      out_frame.vsync <= 1'b0;
      out_frame.href  <= 1'b0;
      out_frame.clken <= 1'b0;
      out_frame.gray  <= '0;
      col             <= '0;
      row             <= '0;
      cols_capt       <= '0;
      err             <= 1'b0;
      mode_sh         <= 2'd0;
      fill_sh         <= 8'd0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      frame_cols      <= '0;
      frame_rows      <= '0;
      frame_cnt       <= '0;
    end else begin
      vsync_p1        <= in_frame.vsync;
      href_p1         <= in_frame.href;
      out_frame.vsync <= gate & in_frame.vsync;
      out_frame.href  <= gate & in_frame.href;
      out_frame.clken <= gate & in_frame.clken;
      out_frame.gray  <= gate ? pix_cur : '0;
      frame_done      <= eof_now;

      case (state)
        WAIT_SOF: if (sof) state <= IN_FRAME;
        IN_FRAME: if (vs_fall) state <= EOF;
        EOF:      state <= sof ? IN_FRAME : WAIT_SOF;
        default:  state <= WAIT_SOF;
      endcase

      if (sof) begin
        col       <= (in_frame.href && in_frame.clken) ? CNT_W'(1) : '0;
        row       <= '0;
        err       <= 1'b0;
        cols_capt <= '0;
        mode_sh   <= cfg_border_mode;
        fill_sh   <= cfg_fill;
      end else begin
        if (href_fall)
          col <= '0;
        else if (in_frame.href && in_frame.clken)
          col <= sat_inc(col);
        row       <= row_nxt;
        err       <= err_nxt;
        cols_capt <= capt_nxt;
      end

      if (eof_now) begin
        frame_rows <= row_nxt;
        frame_err  <= err_nxt | (row_nxt != H_C);
        frame_cols <= capt_nxt;
        frame_cnt  <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
